// File: rtl/uart_word_tx.sv
// uart_word_tx: buffers 32-bit words in a small FIFO and sends each as four
// LSB-first 8N1 UART frames, least-significant byte first.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        tx,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   word;
    logic          nonempty, push, pop, bit_end, cont;

    always_comb begin
        nonempty = count != '0;
        in_ready = count != FULL;
        push = in_valid && in_ready;
        bit_end = baud_cnt == BAUD_LAST;
        pop = nonempty && (state == IDLE || (state == STOP && bit_end && byte_idx == 2'd3));
        cont = byte_idx != 2'd3 || pop;
        busy = state != IDLE || nonempty;
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end

    // word[{byte_idx, bit_idx}] addresses bit byte_idx*8+bit_idx directly
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            tx <= 1'b1;
            baud_cnt <= '0;
            bit_idx <= '0;
            byte_idx <= '0;
            word <= '0;
        end else begin
            baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: if (pop) begin
                    word <= mem[rd_ptr];
                    byte_idx <= '0;
                    tx <= 1'b0;
                    state <= START;
                end
                START: if (bit_end) begin
                    bit_idx <= '0;
                    tx <= word[{byte_idx, 3'd0}];
                    state <= DATA;
                end
                DATA: if (bit_end) begin
                    bit_idx <= bit_idx + 1'b1;
                    tx <= bit_idx == 3'd7 ? 1'b1 : word[{byte_idx, bit_idx + 3'd1}];
                    state <= bit_idx == 3'd7 ? STOP : DATA;
                end
                STOP: if (bit_end) begin
                    byte_idx <= byte_idx + 1'b1;
                    word <= pop ? mem[rd_ptr] : word;
                    tx <= !cont;
                    state <= cont ? START : IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: scoreboard bench; the driver queues expected bytes on accept,
// a UART decoder process pops and compares each received frame.
module tb_uart_word_tx;
    localparam int CPB = 4;
    localparam int CPB_B = 868;

    logic clk = 0, rst = 0;
    logic in_valid = 0, in_valid_b = 0;
    logic [31:0] in_data = 0, in_data_b = 0;
    logic in_ready, tx, busy, in_ready_b, tx_b, busy_b;
    int checks = 0, errors = 0;
    int cyc = 0, epoch = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    uart_word_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx(tx), .busy(busy)
    );

    uart_word_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst) epoch <= epoch + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents w from the current negedge until accepted; returns wait cycles.
    task automatic send(input logic [31:0] w, output int waited);
        in_valid = 1;
        in_data = w;
        waited = 0;
        while (!in_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %0h never accepted", w);
        end else
            for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
        @(negedge clk);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // UART decoder on dut.tx: mid-bit sampling, frames spanning a reset are dropped.
    initial begin
        int fs, ep;
        logic [7:0] d;
        logic ok;
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) begin
                fs = cyc;
                ep = epoch;
                d = '0;
                repeat (CPB / 2) @(negedge clk);
                ok = tx === 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                ok = ok && tx === 1'b1;
                if (ep == epoch && rst) begin
                    starts.push_back(fs);
                    check("frame_format", ok, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", d);
                    end else
                        check("frame_byte", d, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, e;
        logic lvl;
        int seg[8] = '{868, 7812, 7812, 868, 7812, 868, 7812, 868};
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        check("rst_tx_b", tx_b, 1);
        check("rst_ready_b", in_ready_b, 1);
        rst = 1;

        e = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) e++;
        end
        check("idle_hold", e, 0);

        send(32'h11223344, w);
        in_valid = 0;
        check("tx_before_pop", tx, 1);
        @(negedge clk);
        check("start_at_e1", tx, 0);
        wait_idle(n);
        check("busy_span", n, 160);
        repeat (5) @(negedge clk);
        check("single_drained", exp_q.size(), 0);

        starts.delete();
        send(32'hA0000001, w);
        for (int i = 2; i <= 5; i++) begin
            send(32'hA0000000 | 32'(i), w);
            check("burst_no_wait", w, 0);
        end
        check("ready_low_full", in_ready, 0);
        send(32'hA0000006, w);
        in_valid = 0;
        check("backpressure_cycles", w, 157);
        wait_idle(n);
        repeat (5) @(negedge clk);
        check("burst_frames", starts.size(), 24);
        check("burst_span", starts.size() >= 24 ? starts[23] - starts[0] : -1, 920);
        check("burst_drained", exp_q.size(), 0);

        send(32'hC3C2C1C0, w);
        send(32'hD3D2D1D0, w);
        send(32'hE3E2E1E0, w);
        in_valid = 0;
        repeat (90) @(negedge clk);
        #2 rst = 0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_ready", in_ready, 1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1;

        e = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_data = 32'hFFFF0000 ^ 32'(i * 32'h01010101);
            if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) e++;
        end
        check("post_rst_quiet", e, 0);

        send(32'h5AA55AA5, w);
        in_valid = 0;
        wait_idle(n);
        repeat (5) @(negedge clk);
        check("resume_drained", exp_q.size(), 0);

        in_valid_b = 1;
        in_data_b = 32'h000000FF;
        @(negedge clk);
        in_valid_b = 0;
        n = 0;
        while (tx_b && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("baud_latency", n, 1);
        for (int i = 0; i < 8; i++) begin
            lvl = i % 2 == 1;
            n = 0;
            while (tx_b == lvl && (!lvl || busy_b) && n < 10000) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("baud_seg%0d", i), n, seg[i]);
        end
        check("baud_end_tx", tx_b, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Serializes 32-bit result words from the DCT datapath onto the UART transmit line as four 8N1 frames, least-significant byte first. It sits at the output end of the processing pipeline, after the fixed-latency multiplier/delay buffers, and drains their words back to the host. A small word FIFO absorbs bursts so upstream stages can stall on `in_ready` rather than drop data.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit period (100 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 4, word FIFO depth; power of two, ≥ 2.

- `clk` input 1: single clock; all logic is synchronous to its rising edge.
- `rst` input 1: reset, asynchronous and active-low. Asserting it clears all state immediately. Release is sampled on `clk`.
- `in_valid` input 1: `in_data` holds a word to send.
- `in_data` input 32: word to transmit.
- `in_ready` output 1: FIFO can accept a word this cycle.
- `tx` output 1: UART serial line, idle high, registered.
- `busy` output 1: a frame is in progress or the FIFO is non-empty.

## Operation
- Reset values: `tx`=1, `busy`=0, `in_ready`=1 (FIFO empty). FIFO pointers, count, FSM, bit/byte/baud counters are all 0.
- Accept rule:
  - A word is written when `in_valid && in_ready` at a rising edge.
  - `in_ready = (count != FIFO_DEPTH)`, combinational from the registered count.
  - When full, `in_ready`=0 even if a pop occurs in the same cycle. There is no same-cycle write-through.
  - `in_data` is ignored when not accepted.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head word into the shift word, set byte_idx=0, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit_idx=0.
  - DATA: `tx` = bit `bit_idx` of byte `byte_idx`, LSB first, each bit for `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end of the stop bit:
    - if byte_idx<3: byte_idx++, go to START;
    - else if the FIFO is non-empty: pop, byte_idx=0, go to START (no idle gap between words);
    - else go to IDLE.
- Byte order: in_data[7:0], [15:8], [23:16], [31:24].
- Baud counter: counts 0..`CLKS_PER_BIT`-1. Wraps to 0 on each bit boundary. Width is $clog2(`CLKS_PER_BIT`).
- Count update: count increments on push only, decrements on pop only, and is unchanged on simultaneous push+pop. Pointers wrap modulo `FIFO_DEPTH`.
- `busy` = (state != IDLE) || (count != 0).
- Reset mid-frame: `tx` returns to 1 asynchronously. The partial frame and all FIFO contents are discarded. After release the block resumes in IDLE.

## Timing
- Push at edge E into an empty FIFO with FSM in IDLE: the pop happens at E+1 and `tx` goes low after E+1. This gives 1 cycle of latency from acceptance to the start bit.
- One frame = 10×`CLKS_PER_BIT` cycles. One word = 40×`CLKS_PER_BIT` cycles, with no gaps between bytes or between back-to-back words.
- `tx` is glitch-free: a register output, changing only on bit boundaries.
- Capacity: up to `FIFO_DEPTH` words queued plus one in flight.

## Test plan
- **Single word.** Set `CLKS_PER_BIT`=4 and push 0x11223344. Required response:
  - `tx` decodes to bytes 0x44, 0x33, 0x22, 0x11, each framed 0/data/1;
  - `tx` is low at cycle E+1;
  - `busy` falls exactly 160 cycles after the start bit begins.
- **Burst and backpressure.** Hold `in_valid`=1 with words 0xA0000001..0xA0000006 and depth 4. Required response:
  - the first 5 words are accepted (1 in flight plus 4 queued);
  - `in_ready`=0 until the first word finishes;
  - all 6 words appear in order with no idle bits between frames.
- **Baud accuracy.** Set `CLKS_PER_BIT`=868 and send 0x000000FF. Every bit period measures exactly 868 cycles, and byte 0 reads 0xFF followed by three 0x00 frames.
- **Reset mid-frame.** Assert `rst` low during DATA of byte 2 with 2 words queued. Required response:
  - `tx`=1 immediately, `busy`=0, `in_ready`=1;
  - after release there is no further transmission until a new push.
- **Idle hold.** With no pushes for 1000 cycles after reset, `tx` stays at 1, `busy` at 0, and `in_ready` at 1.
- **Ignored data.** Toggle `in_data` while `in_valid`=0. Nothing is queued and `tx` stays idle.
